// File: rtl/tinyarch_host_pkg.sv
// Shared types and constants for the tinyarch host-side run controller.
// Command opcodes, response status codes and controller states live here.
package tinyarch_host_pkg;

  localparam int RSP_W = 16;

  typedef enum logic [1:0] {
    OP_WR_IMEM = 2'd0,
    OP_WR_DMEM = 2'd1,
    OP_RUN     = 2'd2,
    OP_RD_DMEM = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_TIMEOUT = 2'd1
  } rsp_status_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_START   = 3'd3,
    ST_RUN     = 3'd4,
    ST_ABORT   = 3'd5,
    ST_RSP     = 3'd6
  } run_state_e;

endpackage

// File: rtl/tinyarch_run_ctrl_run_timer.sv
// Saturating run-cycle counter with a timeout compare.
// count_inc is the count including the current cycle, so callers can act on it immediately.
module run_timer
  import tinyarch_host_pkg::*;
#(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [RSP_W-1:0] count,
  output logic [RSP_W-1:0] count_inc,
  output logic             expired
);

  localparam logic [RSP_W-1:0] CNT_MAX   = {RSP_W{1'b1}};
  localparam logic [RSP_W-1:0] TIMEOUT_V = RSP_W'(TIMEOUT);

  // Saturating increment and timeout compare on the including-this-cycle value
  always_comb begin
    count_inc = count;
    if (count == CNT_MAX) begin
      count_inc = count;
    end else begin
      count_inc = count + {{(RSP_W-1){1'b0}}, 1'b1};
    end
    expired = (count_inc >= TIMEOUT_V);
  end

  // Counter register: clear has priority over increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= {RSP_W{1'b0}};
    end else if (clear) begin
      count <= {RSP_W{1'b0}};
    end else if (inc) begin
      count <= count_inc;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/tinyarch_run_ctrl.sv
// Host-side initiator for the tinyarch start/done run protocol: memory preload,
// data readback and timed program runs, all outputs registered.
module tinyarch_run_ctrl
  import tinyarch_host_pkg::*;
#(
  parameter int IADDR_W          = 16,
  parameter int IDATA_W          = 9,
  parameter int DADDR_W          = 8,
  parameter int DDATA_W          = 8,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [IADDR_W-1:0] cmd_addr,
  input  logic [IDATA_W-1:0] cmd_data,
  output logic               imem_we,
  output logic [IADDR_W-1:0] imem_addr,
  output logic [IDATA_W-1:0] imem_wdata,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DDATA_W-1:0] dmem_wdata,
  input  logic [DDATA_W-1:0] dmem_rdata,
  output logic               core_start,
  output logic               core_reset,
  input  logic               core_done,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_status,
  output logic [RSP_W-1:0]   rsp_data
);

  run_state_e          state, state_nxt;
  logic                imem_we_nxt, dmem_we_nxt;
  logic [IADDR_W-1:0]  imem_addr_nxt;
  logic [IDATA_W-1:0]  imem_wdata_nxt;
  logic [DADDR_W-1:0]  dmem_addr_nxt;
  logic [DDATA_W-1:0]  dmem_wdata_nxt;
  logic [1:0]          rsp_status_nxt;
  logic [RSP_W-1:0]    rsp_data_nxt;
  logic                timer_clear, timer_inc, timer_expired;
  logic [RSP_W-1:0]    timer_count, timer_count_inc;

  run_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_run_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (timer_clear),
    .inc       (timer_inc),
    .count     (timer_count),
    .count_inc (timer_count_inc),
    .expired   (timer_expired)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt      = state;
    imem_we_nxt    = 1'b0;
    dmem_we_nxt    = 1'b0;
    imem_addr_nxt  = imem_addr;
    imem_wdata_nxt = imem_wdata;
    dmem_addr_nxt  = dmem_addr;
    dmem_wdata_nxt = dmem_wdata;
    rsp_status_nxt = rsp_status;
    rsp_data_nxt   = rsp_data;
    timer_clear    = 1'b0;
    timer_inc      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op_e'(cmd_op))
            OP_WR_IMEM: begin
              state_nxt      = ST_WRITE;
              imem_we_nxt    = 1'b1;
              imem_addr_nxt  = cmd_addr;
              imem_wdata_nxt = cmd_data;
            end
            OP_WR_DMEM: begin
              state_nxt      = ST_WRITE;
              dmem_we_nxt    = 1'b1;
              dmem_addr_nxt  = cmd_addr[DADDR_W-1:0];
              dmem_wdata_nxt = cmd_data[DDATA_W-1:0];
            end
            OP_RUN: begin
              state_nxt = ST_START;
            end
            OP_RD_DMEM: begin
              state_nxt     = ST_RD_WAIT;
              dmem_addr_nxt = cmd_addr[DADDR_W-1:0];
            end
            default: begin
              state_nxt = ST_IDLE;
            end
          endcase
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WRITE: begin
        state_nxt = ST_IDLE;
      end
      ST_RD_WAIT: begin
        state_nxt      = ST_RSP;
        rsp_status_nxt = RSP_OK;
        rsp_data_nxt   = RSP_W'(dmem_rdata);
      end
      ST_START: begin
        timer_clear = 1'b1;
        state_nxt   = ST_RUN;
      end
      ST_RUN: begin
        timer_inc = 1'b1;
        // A zero count marks the first RUN cycle, where done may still be stale
        if (core_done && (timer_count != {RSP_W{1'b0}})) begin
          state_nxt      = ST_RSP;
          rsp_status_nxt = RSP_OK;
          rsp_data_nxt   = timer_count_inc;
        end else if (timer_expired) begin
          state_nxt = ST_ABORT;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_ABORT: begin
        state_nxt      = ST_RSP;
        rsp_status_nxt = RSP_TIMEOUT;
        rsp_data_nxt   = RSP_W'(TIMEOUT);
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_RSP;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output registers, loaded from the decoded next values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_ready  <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= {IADDR_W{1'b0}};
      imem_wdata <= {IDATA_W{1'b0}};
      dmem_we    <= 1'b0;
      dmem_addr  <= {DADDR_W{1'b0}};
      dmem_wdata <= {DDATA_W{1'b0}};
      core_start <= 1'b0;
      core_reset <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_status <= 2'd0;
      rsp_data   <= {RSP_W{1'b0}};
    end else begin
      cmd_ready  <= (state_nxt == ST_IDLE);
      imem_we    <= imem_we_nxt;
      imem_addr  <= imem_addr_nxt;
      imem_wdata <= imem_wdata_nxt;
      dmem_we    <= dmem_we_nxt;
      dmem_addr  <= dmem_addr_nxt;
      dmem_wdata <= dmem_wdata_nxt;
      core_start <= (state_nxt == ST_START);
      core_reset <= (state_nxt == ST_ABORT);
      rsp_valid  <= (state_nxt == ST_RSP);
      rsp_status <= rsp_status_nxt;
      rsp_data   <= rsp_data_nxt;
    end
  end

endmodule

// File: tb/tb_tinyarch_run_ctrl.sv
// Directed bench for tinyarch_run_ctrl with a small data memory and a scripted core.
module tb_tinyarch_run_ctrl;

  localparam int TO = 20;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [8:0]  cmd_data;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [8:0]  imem_wdata;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [7:0]  dmem_wdata;
  logic [7:0]  dmem_rdata;
  logic        core_start;
  logic        core_reset;
  logic        core_done;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_status;
  logic [15:0] rsp_data;

  int tests = 0;
  int fails = 0;

  logic [7:0] dmem [0:255];

  tinyarch_run_ctrl #(
    .IADDR_W (16),
    .IDATA_W (9),
    .DADDR_W (8),
    .DDATA_W (8),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .core_start (core_start),
    .core_reset (core_reset),
    .core_done  (core_done),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_status (rsp_status),
    .rsp_data   (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: synchronous write, combinational read
  always @(posedge clk) begin
    if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
  end
  assign dmem_rdata = dmem[dmem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a command; the caller guarantees the controller is idle at the next edge
  task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [8:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input logic [1:0] st, input logic [15:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_status"}, rsp_status, st);
    check({tag, "_data"}, rsp_data, d);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, "_drop"}, rsp_valid, 0);
    check({tag, "_ready"}, cmd_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int seen_rsp;
    int seen_abort;
    int seen_start;
    logic found;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_addr  = 16'h0000;
    cmd_data  = 9'h000;
    core_done = 1'b0;
    rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_imem_we", imem_we, 0);
    check("rst_core_start", core_start, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // WR_IMEM: one-cycle strobe with registered address/data
    issue(2'd0, 16'h0003, 9'h1A5);
    @(negedge clk);
    check("wri_we", imem_we, 1);
    check("wri_addr", imem_addr, 16'h0003);
    check("wri_wdata", imem_wdata, 9'h1A5);
    check("wri_ready", cmd_ready, 0);
    check("wri_dmem_we", dmem_we, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("wri_we_drop", imem_we, 0);
    check("wri_ready_back", cmd_ready, 1);

    // WR_DMEM then readback
    issue(2'd1, 16'h0042, 9'h07E);
    @(negedge clk);
    check("wrd_we", dmem_we, 1);
    check("wrd_addr", dmem_addr, 8'h42);
    check("wrd_wdata", dmem_wdata, 8'h7E);
    @(posedge clk); #1;
    issue(2'd1, 16'hFF10, 9'h1A5);
    @(negedge clk);
    check("wrd2_addr_low", dmem_addr, 8'h10);
    check("wrd2_data_low", dmem_wdata, 8'hA5);
    @(posedge clk); #1;
    issue(2'd3, 16'h0042, 9'h000);
    @(negedge clk);
    check("rd_wait_addr", dmem_addr, 8'h42);
    check("rd_wait_novalid", rsp_valid, 0);
    check("rd_wait_dmem_we", dmem_we, 0);
    wait_rsp("rd42", 2'd0, 16'h007E);
    issue(2'd3, 16'h0010, 9'h000);
    wait_rsp("rd10", 2'd0, 16'h00A5);

    // RUN: stale done held through the first RUN cycle, real done 10 cycles after start
    core_done = 1'b1;
    issue(2'd2, 16'h0000, 9'h000);
    @(negedge clk);
    check("run_start", core_start, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("run_start_drop", core_start, 0);
    check("run_stale_ignored", rsp_valid, 0);
    @(posedge clk); #1;
    core_done = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    core_done = 1'b1;
    wait_rsp("run_done", 2'd0, 16'd10);
    core_done = 1'b0;

    // RUN with no done: abort after TO counted cycles
    issue(2'd2, 16'h0000, 9'h000);
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (core_reset === 1'b1) found = 1'b1;
      else n++;
    end
    check("abort_seen", found, 1);
    check("abort_cycle", n, TO + 1);
    @(negedge clk);
    check("abort_pulse_drop", core_reset, 0);
    check("abort_rsp_valid", rsp_valid, 1);
    wait_rsp("timeout", 2'd1, 16'd20);

    // Response back-pressure with a pending command
    issue(2'd3, 16'h0042, 9'h000);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_addr  = 16'h1234;
    cmd_data  = 9'h0F0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, 16'h007E);
      check("bp_ready_low", cmd_ready, 0);
      check("bp_no_write", imem_we, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_drop", rsp_valid, 0);
    check("bp_ready_back", cmd_ready, 1);
    check("bp_still_no_write", imem_we, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("bp_cmd_we", imem_we, 1);
    check("bp_cmd_addr", imem_addr, 16'h1234);
    @(posedge clk); #1;

    // Reset asserted mid-RUN
    issue(2'd2, 16'h0000, 9'h000);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_core_start", core_start, 0);
    check("mid_rst_core_reset", core_reset, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_dmem_addr", dmem_addr, 0);
    check("mid_rst_imem_addr", imem_addr, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    seen_rsp   = 0;
    seen_abort = 0;
    seen_start = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen_rsp++;
      if (core_reset === 1'b1) seen_abort++;
      if (core_start === 1'b1) seen_start++;
    end
    check("post_rst_no_rsp", seen_rsp, 0);
    check("post_rst_no_abort", seen_abort, 0);
    check("post_rst_no_start", seen_start, 0);
    check("post_rst_idle", cmd_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
